macc_addr_gen: RTL and testbench

MACC_ADDR_GEN -- requirements
Module: macc_addr_gen

---
 rtl/macc_addr_gen.sv | 97 +++++++++
 tb/tb_macc_addr_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/macc_addr_gen.sv
// rtl/macc_addr_gen.sv - row-major matrix address generator pacing an upstream 2D row/col counter
// Optional addr_last output is built only when MACC_ADDR_GEN_LAST_EN is defined.
module macc_addr_gen (
   input  logic        VDD,
   input  logic        GND,
   input  logic        CLK,
   input  logic        RST_L,
   input  logic        start,
   input  logic [15:0] base_addr,
   input  logic [9:0]  row_stride,
   input  logic [9:0]  row_max,
   input  logic [9:0]  col_max,
   input  logic [9:0]  row,
   input  logic [9:0]  col,
   output logic        inc,
   output logic [15:0] addr,
   output logic        addr_vld,
   input  logic        addr_rdy,
   output logic        busy,
   output logic        done
`ifdef MACC_ADDR_GEN_LAST_EN
   ,
   output logic        addr_last
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GEN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [19:0] row_off;
   logic [15:0] addr_nxt;
   logic        is_last;
   logic        accept;
   logic [5:0]  unused_bits;

   // Supply pins and the high product bits carry no logic function.
   assign unused_bits = {VDD, GND, row_off[19:16]};

   assign row_off  = {10'd0, row} * {10'd0, row_stride};
   assign addr_nxt = base_addr + row_off[15:0] + {6'd0, col};
   assign is_last  = (row == row_max) && (col == col_max);
   assign accept   = addr_vld && addr_rdy;

   // Advancing only when the output register is free keeps counter and addr in lock-step.
   assign inc  = (state == GEN) && (!addr_vld || addr_rdy);
   assign busy = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = GEN;
         GEN:     if (inc && is_last) state_nxt = DRAIN;
         DRAIN:   if (accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         addr     <= 16'd0;
         addr_vld <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= (state == DRAIN) && accept;
         if (inc) begin
            addr     <= addr_nxt;
            addr_vld <= 1'b1;
         end else if (accept) begin
            addr_vld <= 1'b0;
         end
      end
   end

`ifdef MACC_ADDR_GEN_LAST_EN
   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         addr_last <= 1'b0;
      end else if (inc) begin
         addr_last <= is_last;
      end
   end
`endif

endmodule

// File: tb/tb_macc_addr_gen.sv
// tb/tb_macc_addr_gen.sv - self-checking bench for macc_addr_gen with an upstream counter model
// Checks addr_last too when MACC_ADDR_GEN_LAST_EN is defined.
module tb_macc_addr_gen;

   logic        VDD, GND, CLK, RST_L, start, inc, addr_vld, addr_rdy, busy, done;
   logic [15:0] base_addr, addr;
   logic [9:0]  row_stride, row_max, col_max, row, col;
`ifdef MACC_ADDR_GEN_LAST_EN
   logic        addr_last;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [15:0] base;
      logic [9:0]  stride;
      logic [9:0]  rmax;
      logic [9:0]  cmax;
      int          mode;
      int          exp_n;
      logic [15:0] exp_first;
      logic [15:0] exp_last;
   } vec_t;

   macc_addr_gen dut (
      .VDD        (VDD),
      .GND        (GND),
      .CLK        (CLK),
      .RST_L      (RST_L),
      .start      (start),
      .base_addr  (base_addr),
      .row_stride (row_stride),
      .row_max    (row_max),
      .col_max    (col_max),
      .row        (row),
      .col        (col),
      .inc        (inc),
      .addr       (addr),
      .addr_vld   (addr_vld),
      .addr_rdy   (addr_rdy),
      .busy       (busy),
      .done       (done)
`ifdef MACC_ADDR_GEN_LAST_EN
      ,
      .addr_last  (addr_last)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Upstream 2D counter: row-major walk that wraps back to (0,0).
   always @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         row <= 10'd0;
         col <= 10'd0;
      end else if (inc) begin
         if (col == col_max) begin
            col <= 10'd0;
            row <= (row == row_max) ? 10'd0 : row + 10'd1;
         end else begin
            col <= col + 10'd1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
   endtask

   // mode 0: rdy high; 1: random rdy + stray starts; 2: stall 3 cycles on 0x101; 3: rdy high + start held while busy
   task automatic run_pass(input vec_t v);
      logic [15:0] exp_q[$];
      logic [15:0] e, held, first_a, last_a;
      bit          stalled, done_seen;
      int          stall_cnt, budget, n_seen, n_inc, n_done, cycles;
      n_seen = 0; n_inc = 0; n_done = 0; cycles = 0; stall_cnt = 0;
      stalled = 0; done_seen = 0; held = '0; first_a = '0; last_a = '0;
      for (int r = 0; r <= int'(v.rmax); r++)
         for (int c = 0; c <= int'(v.cmax); c++)
            exp_q.push_back(16'(int'(v.base) + r * int'(v.stride) + c));
      base_addr = v.base; row_stride = v.stride; row_max = v.rmax; col_max = v.cmax;
      addr_rdy = 1'b1; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      #1;
      chk("busy_after_start", busy, 1);
      chk("vld_low_first_gen_cycle", addr_vld, 0);
      budget = 60 * exp_q.size() + 40;
      while (!done_seen && cycles < budget) begin
         if (done) begin
            n_done++;
            done_seen = 1;
         end else begin
            if (stalled) chk("stall_addr_hold", addr, held);
            case (v.mode)
               1: begin
                  addr_rdy = ($urandom_range(0, 3) != 0);
                  start    = busy && ($urandom_range(0, 4) == 0);
               end
               2: begin
                  if (addr_vld && addr == 16'h0101 && stall_cnt < 3) begin
                     addr_rdy = 1'b0;
                     stall_cnt++;
                  end else addr_rdy = 1'b1;
               end
               3: begin
                  addr_rdy = 1'b1;
                  start    = busy;
               end
               default: addr_rdy = 1'b1;
            endcase
            #1;
            if (inc) n_inc++;
            if (addr_vld && !addr_rdy) chk("inc_low_while_stalled", inc, 0);
            stalled = addr_vld && !addr_rdy;
            held    = addr;
            if (addr_vld && addr_rdy) begin
               if (exp_q.size() == 0) chk("extra_addr", addr_vld, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("addr", addr, e);
`ifdef MACC_ADDR_GEN_LAST_EN
                  chk("addr_last", addr_last, exp_q.size() == 0);
`endif
                  if (n_seen == 0) first_a = addr;
                  last_a = addr;
                  n_seen++;
               end
            end
            @(negedge CLK);
            #1;
            cycles++;
         end
      end
      start = 1'b0;
      addr_rdy = 1'b1;
      if (!done_seen) chk("pass_timeout", 0, 1);
      else chk("busy_low_at_done", busy, 0);
      chk("all_addrs_seen", exp_q.size(), 0);
      chk("n_addr", n_seen, v.exp_n);
      chk("n_inc", n_inc, v.exp_n);
      chk("first_addr", first_a, v.exp_first);
      chk("last_addr", last_a, v.exp_last);
      if (v.mode == 0 || v.mode == 3) chk("pass_cycles", cycles, v.exp_n + 1);
      if (v.mode == 2) begin
         chk("stall_cycles", stall_cnt, 3);
         chk("pass_cycles_stalled", cycles, v.exp_n + 4);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         #1;
         if (done) n_done++;
      end
      chk("done_pulses", n_done, 1);
      chk("idle_after_pass", busy, 0);
   endtask

   initial begin
      vec_t tbl[6];
      vec_t rv;
      int   hs;
      tbl[0] = '{16'h0100, 10'd4,     10'd1, 10'd2, 0, 6,  16'h0100, 16'h0106};
      tbl[1] = '{16'h0100, 10'd4,     10'd1, 10'd2, 2, 6,  16'h0100, 16'h0106};
      tbl[2] = '{16'hFFFE, 10'd1,     10'd0, 10'd3, 0, 4,  16'hFFFE, 16'h0001};
      tbl[3] = '{16'h1234, 10'd7,     10'd0, 10'd0, 3, 1,  16'h1234, 16'h1234};
      tbl[4] = '{16'h0010, 10'h3FF,   10'd2, 10'd1, 0, 6,  16'h0010, 16'h080F};
      tbl[5] = '{16'hF000, 10'h3FF,   10'd5, 10'd3, 1, 24, 16'hF000, 16'h03FE};

      VDD = 1'b1; GND = 1'b0; RST_L = 1'b0; start = 1'b0; addr_rdy = 1'b0;
      base_addr = '0; row_stride = '0; row_max = '0; col_max = '0;
      #12;
      chk("rst_addr", addr, 0);
      chk("rst_vld", addr_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_inc", inc, 0);
`ifdef MACC_ADDR_GEN_LAST_EN
      chk("rst_addr_last", addr_last, 0);
`endif
      @(negedge CLK);
      RST_L = 1'b1;
      @(negedge CLK);
      #1;
      chk("idle_without_start", busy, 0);

      for (int i = 0; i < 6; i++) run_pass(tbl[i]);

      // Reset during a pass, after the third address is accepted.
      base_addr = 16'h0100; row_stride = 10'd4; row_max = 10'd1; col_max = 10'd2;
      addr_rdy = 1'b1; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      hs = 0;
      for (int k = 0; k < 20 && hs < 3; k++) begin
         #1;
         if (addr_vld && addr_rdy) hs++;
         @(negedge CLK);
      end
      chk("reached_third_addr", hs, 3);
      #2;
      RST_L = 1'b0;
      #1;
      chk("abort_addr", addr, 0);
      chk("abort_vld", addr_vld, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_inc", inc, 0);
      @(negedge CLK);
      RST_L = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         #1;
         chk("post_abort_no_done", done, 0);
         chk("post_abort_idle", busy, 0);
      end

      for (int i = 0; i < 30; i++) begin
         rv.base   = 16'($urandom);
         rv.stride = 10'($urandom_range(0, 1023));
         rv.rmax   = 10'($urandom_range(0, 4));
         rv.cmax   = 10'($urandom_range(0, 4));
         rv.mode   = 1;
         rv.exp_n  = (int'(rv.rmax) + 1) * (int'(rv.cmax) + 1);
         rv.exp_first = rv.base;
         rv.exp_last  = 16'(int'(rv.base) + int'(rv.rmax) * int'(rv.stride) + int'(rv.cmax));
         run_pass(rv);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
